// File: rtl/fetch_decode.sv
// Fetch/decode front end: program counter, instruction register, ALU flag
// registers and a combinational opcode/register-field decoder.
package k_and_s_pkg;
    typedef enum logic [3:0] {
        I_NOP, I_BRANCH, I_BZERO, I_BNEG, I_LOAD, I_STORE,
        I_MOVE, I_ADD, I_SUB, I_AND, I_OR, I_HALT
    } decoded_instruction_type;
endpackage

module fetch_decode
    import k_and_s_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pc_enable,
    input  logic                    branch,
    input  logic                    ir_enable,
    input  logic                    addr_sel,
    input  logic                    flags_reg_enable,
    input  logic [15:0]             data_in,
    input  logic                    alu_zero,
    input  logic                    alu_neg,
    input  logic                    alu_uovf,
    input  logic                    alu_sovf,
    output logic [4:0]              ram_addr,
    output decoded_instruction_type decoded_instruction,
    output logic [1:0]              a_addr,
    output logic [1:0]              b_addr,
    output logic [1:0]              c_addr,
    output logic [4:0]              mem_addr,
    output logic                    zero_op,
    output logic                    neg_op,
    output logic                    unsigned_overflow,
    output logic                    signed_overflow
);

    logic [4:0]  r_pc;
    logic [15:0] r_ir;
    logic        r_zero;
    logic        r_neg;
    logic        r_uovf;
    logic        r_sovf;
    logic [4:0]  w_mem_addr;

    assign w_mem_addr = r_ir[4:0];

    // Branch target comes from the IR contents before this edge, so a
    // simultaneous IR load never redirects the same-cycle branch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= '0;
            r_ir <= '0;
        end else begin
            if (pc_enable) begin
                if (branch)
                    r_pc <= w_mem_addr;
                else
                    r_pc <= r_pc + 5'd1;
            end
            if (ir_enable)
                r_ir <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
            r_uovf <= 1'b0;
            r_sovf <= 1'b0;
        end else if (flags_reg_enable) begin
            r_zero <= alu_zero;
            r_neg  <= alu_neg;
            r_uovf <= alu_uovf;
            r_sovf <= alu_sovf;
        end
    end

    always_comb begin
        decoded_instruction = I_NOP;
        a_addr = '0;
        b_addr = '0;
        c_addr = '0;
        case (r_ir[15:8])
            8'h01: decoded_instruction = I_BRANCH;
            8'h02: decoded_instruction = I_BZERO;
            8'h03: decoded_instruction = I_BNEG;
            8'h81: begin
                decoded_instruction = I_LOAD;
                c_addr = r_ir[6:5];
            end
            8'h82: begin
                decoded_instruction = I_STORE;
                a_addr = r_ir[6:5];
            end
            8'h91: begin
                decoded_instruction = I_MOVE;
                c_addr = r_ir[3:2];
                a_addr = r_ir[1:0];
                b_addr = r_ir[1:0];
            end
            8'hA1, 8'hA2, 8'hA3, 8'hA4: begin
                case (r_ir[9:8])
                    2'b01:   decoded_instruction = I_ADD;
                    2'b10:   decoded_instruction = I_SUB;
                    2'b11:   decoded_instruction = I_AND;
                    default: decoded_instruction = I_OR;
                endcase
                c_addr = r_ir[5:4];
                a_addr = r_ir[3:2];
                b_addr = r_ir[1:0];
            end
            8'hFF: decoded_instruction = I_HALT;
            default: decoded_instruction = I_NOP;
        endcase
    end

    assign ram_addr          = addr_sel ? w_mem_addr : r_pc;
    assign mem_addr          = w_mem_addr;
    assign zero_op           = r_zero;
    assign neg_op            = r_neg;
    assign unsigned_overflow = r_uovf;
    assign signed_overflow   = r_sovf;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: PC sequencing/wrap, decode table,
// simultaneous IR/PC update, flag hold and reset priority.
module tb_fetch_decode;
    import k_and_s_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_enable;
    logic        branch;
    logic        ir_enable;
    logic        addr_sel;
    logic        flags_reg_enable;
    logic [15:0] data_in;
    logic        alu_zero;
    logic        alu_neg;
    logic        alu_uovf;
    logic        alu_sovf;
    logic [4:0]  ram_addr;
    decoded_instruction_type decoded_instruction;
    logic [1:0]  a_addr;
    logic [1:0]  b_addr;
    logic [1:0]  c_addr;
    logic [4:0]  mem_addr;
    logic        zero_op;
    logic        neg_op;
    logic        unsigned_overflow;
    logic        signed_overflow;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    fetch_decode dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .pc_enable           (pc_enable),
        .branch              (branch),
        .ir_enable           (ir_enable),
        .addr_sel            (addr_sel),
        .flags_reg_enable    (flags_reg_enable),
        .data_in             (data_in),
        .alu_zero            (alu_zero),
        .alu_neg             (alu_neg),
        .alu_uovf            (alu_uovf),
        .alu_sovf            (alu_sovf),
        .ram_addr            (ram_addr),
        .decoded_instruction (decoded_instruction),
        .a_addr              (a_addr),
        .b_addr              (b_addr),
        .c_addr              (c_addr),
        .mem_addr            (mem_addr),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pc_enable = 1'b0;
        branch = 1'b0;
        ir_enable = 1'b0;
        flags_reg_enable = 1'b0;
        addr_sel = 1'b0;
    endtask

    task automatic load_ir(input logic [15:0] v);
        ir_enable = 1'b1;
        data_in = v;
        tick();
        ir_enable = 1'b0;
    endtask

    task automatic check_decode(input string tag, input decoded_instruction_type op,
                                input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
        check({tag, ".op"}, 16'(decoded_instruction), 16'(op));
        check({tag, ".a"}, 16'(a_addr), 16'(a));
        check({tag, ".b"}, 16'(b_addr), 16'(b));
        check({tag, ".c"}, 16'(c_addr), 16'(c));
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        data_in = 16'h0000;
        {alu_zero, alu_neg, alu_uovf, alu_sovf} = 4'b0000;
        tick();
        tick();
        check("rst.ram_addr", 16'(ram_addr), 16'h0);
        check_decode("rst", I_NOP, 2'd0, 2'd0, 2'd0);
        check("rst.mem_addr", 16'(mem_addr), 16'h0);
        check("rst.flags", 16'({zero_op, neg_op, unsigned_overflow, signed_overflow}), 16'h0);

        rst_n = 1'b1;
        pc_enable = 1'b1;
        for (int i = 1; i <= 33; i++) begin
            tick();
            check($sformatf("pc_seq%0d", i), 16'(ram_addr), 16'(i % 32));
        end
        pc_enable = 1'b0;
        branch = 1'b1;
        tick();
        check("pc_hold_branch", 16'(ram_addr), 16'h1);
        branch = 1'b0;

        load_ir(16'hA136);
        check_decode("add", I_ADD, 2'd1, 2'd2, 2'd3);
        check("add.mem_addr", 16'(mem_addr), 16'h16);

        load_ir(16'h910E);
        check_decode("move", I_MOVE, 2'd2, 2'd2, 2'd3);
        load_ir(16'h8140);
        check_decode("load", I_LOAD, 2'd0, 2'd0, 2'd2);
        load_ir(16'hA2FF);
        check_decode("sub", I_SUB, 2'd3, 2'd3, 2'd3);
        load_ir(16'hA309);
        check_decode("and", I_AND, 2'd2, 2'd1, 2'd0);
        load_ir(16'hA421);
        check_decode("or", I_OR, 2'd0, 2'd1, 2'd2);
        load_ir(16'hFF3F);
        check_decode("halt", I_HALT, 2'd0, 2'd0, 2'd0);
        load_ir(16'hA53F);
        check_decode("nop_a5", I_NOP, 2'd0, 2'd0, 2'd0);
        load_ir(16'h0203);
        check_decode("bzero", I_BZERO, 2'd0, 2'd0, 2'd0);
        load_ir(16'h0303);
        check_decode("bneg", I_BNEG, 2'd0, 2'd0, 2'd0);

        load_ir(16'h0114);
        check_decode("branch", I_BRANCH, 2'd0, 2'd0, 2'd0);
        pc_enable = 1'b1;
        branch = 1'b1;
        tick();
        idle();
        check("br.pc", 16'(ram_addr), 16'h14);
        addr_sel = 1'b1;
        #1;
        check("br.sel_ir", 16'(ram_addr), 16'h14);
        addr_sel = 1'b0;

        // Branch with a simultaneous IR load: target must come from old IR (0x07).
        load_ir(16'h0107);
        pc_enable = 1'b1;
        branch = 1'b1;
        ir_enable = 1'b1;
        data_in = 16'h0109;
        tick();
        idle();
        check("brsim.pc", 16'(ram_addr), 16'h07);
        check("brsim.mem_addr", 16'(mem_addr), 16'h09);
        addr_sel = 1'b1;
        #1;
        check("brsim.sel_ir", 16'(ram_addr), 16'h09);
        addr_sel = 1'b0;

        pc_enable = 1'b1;
        ir_enable = 1'b1;
        data_in = 16'h8265;
        tick();
        idle();
        check("sim.pc", 16'(ram_addr), 16'h08);
        check_decode("sim", I_STORE, 2'd3, 2'd0, 2'd0);
        check("sim.mem_addr", 16'(mem_addr), 16'h05);

        flags_reg_enable = 1'b1;
        {alu_zero, alu_neg, alu_uovf, alu_sovf} = 4'b1011;
        tick();
        check("flags.load", 16'({zero_op, neg_op, unsigned_overflow, signed_overflow}), 16'hB);
        flags_reg_enable = 1'b0;
        {alu_zero, alu_neg, alu_uovf, alu_sovf} = 4'b0100;
        tick();
        check("flags.hold", 16'({zero_op, neg_op, unsigned_overflow, signed_overflow}), 16'hB);
        flags_reg_enable = 1'b1;
        tick();
        check("flags.load2", 16'({zero_op, neg_op, unsigned_overflow, signed_overflow}), 16'h4);
        {alu_zero, alu_neg, alu_uovf, alu_sovf} = 4'b1111;

        rst_n = 1'b0;
        pc_enable = 1'b1;
        ir_enable = 1'b1;
        data_in = 16'hA136;
        tick();
        idle();
        rst_n = 1'b1;
        #1;
        check("mrst.pc", 16'(ram_addr), 16'h0);
        check("mrst.mem_addr", 16'(mem_addr), 16'h0);
        check_decode("mrst", I_NOP, 2'd0, 2'd0, 2'd0);
        check("mrst.flags", 16'({zero_op, neg_op, unsigned_overflow, signed_overflow}), 16'h0);
        tick();
        check("mrst.fetch0", 16'(ram_addr), 16'h0);
        pc_enable = 1'b1;
        tick();
        idle();
        check("mrst.pc_next", 16'(ram_addr), 16'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
